cb_arb: RTL

CB_ARB -- requirements
Module: cb_arb

---
 rtl/cb_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cb_arb.sv
// cb_arb: crossbar allocator with one round-robin arbiter per output port.
// A grant is held for a whole packet until tail, request withdrawal or watchdog expiry.
`ifndef PORT
`define PORT 3
`endif

module cb_arb #(
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [`PORT:0] r0,
    input  logic [`PORT:0] r1,
    input  logic [`PORT:0] r2,
    input  logic [`PORT:0] r3,
    input  logic           t0,
    input  logic           t1,
    input  logic           t2,
    input  logic           t3,
    output logic [`PORT:0] d0,
    output logic [`PORT:0] d1,
    output logic [`PORT:0] d2,
    output logic [`PORT:0] d3,
    output logic [`PORT:0] busy,
    output logic [`PORT:0] tmo_err
);

    localparam int N  = `PORT + 1;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TMO + 1);
    localparam logic [N-1:0]  ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = CW'(TMO - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    logic [N-1:0]  req      [N];
    logic [N-1:0]  eff      [N];
    logic [N-1:0]  col      [N];
    logic [PW-1:0] winner   [N];
    logic [N-1:0]  tail;
    logic [N-1:0]  anyReq;
    logic [N-1:0]  stillReq;
    logic [N-1:0]  tailHit;
    logic [PW-1:0] idx;

    state_e        state_q  [N];
    logic [N-1:0]  grant_q  [N];
    logic [PW-1:0] ptr_q    [N];
    logic [CW-1:0] cnt_q    [N];
    logic [N-1:0]  tmo_q;

    // Reduce each input to its lowest requested output, then transpose to per-output columns.
    always_comb begin
        req[0] = r0;
        req[1] = r1;
        req[2] = r2;
        req[3] = r3;
        tail   = {t3, t2, t1, t0};
        for (int i = 0; i < N; i++) begin
            eff[i] = req[i] & (-req[i]);
        end
        for (int j = 0; j < N; j++) begin
            col[j] = '0;
            for (int i = 0; i < N; i++) begin
                col[j][i] = eff[i][j];
            end
        end
    end

    // Scan downwards so the last hit is the first requester at or after the pointer.
    always_comb begin
        idx = '0;
        for (int j = 0; j < N; j++) begin
            winner[j]   = '0;
            anyReq[j]   = |col[j];
            stillReq[j] = |(grant_q[j] & col[j]);
            tailHit[j]  = |(grant_q[j] & tail);
            for (int k = N - 1; k >= 0; k--) begin
                idx = ptr_q[j] + PW'(k);
                if (col[j][idx]) begin
                    winner[j] = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tmo_q <= '0;
            for (int j = 0; j < N; j++) begin
                state_q[j] <= IDLE;
                grant_q[j] <= '0;
                ptr_q[j]   <= '0;
                cnt_q[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                tmo_q[j] <= 1'b0;
                case (state_q[j])
                    IDLE: begin
                        grant_q[j] <= '0;
                        if (anyReq[j]) begin
                            grant_q[j] <= ONE << winner[j];
                            ptr_q[j]   <= winner[j] + PW'(1);
                            cnt_q[j]   <= '0;
                            state_q[j] <= BUSY;
                        end
                    end
                    BUSY: begin
                        // A tail or withdrawn request releases normally and masks the watchdog.
                        if (tailHit[j] || !stillReq[j]) begin
                            grant_q[j] <= '0;
                            state_q[j] <= IDLE;
                        end else if (cnt_q[j] == CNT_MAX) begin
                            grant_q[j] <= '0;
                            state_q[j] <= IDLE;
                            cnt_q[j]   <= cnt_q[j] + CW'(1);
                            tmo_q[j]   <= 1'b1;
                        end else begin
                            cnt_q[j]   <= cnt_q[j] + CW'(1);
                        end
                    end
                    default: begin
                        grant_q[j] <= '0;
                        state_q[j] <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            busy[j] = |grant_q[j];
        end
    end

    assign d0      = grant_q[0];
    assign d1      = grant_q[1];
    assign d2      = grant_q[2];
    assign d3      = grant_q[3];
    assign tmo_err = tmo_q;

endmodule
